// File: rtl/clock_divider_controller.sv
// clock_divider_controller
//   Run-time controller for the board clock divider. Owns the active
//   half-period count and sequences start, stop and rate changes so that
//   clock_signal never produces a runt high phase.
//
// Ports
//   clk_FPGA        : single clock, rising edge
//   reset           : synchronous, active-low
//   enable          : run request (level)
//   cfg_valid       : new half-period offered
//   cfg_half_period : requested half-period in clk_FPGA cycles
//   cfg_ready       : config accepted this cycle if offered (decoded from state)
//   cfg_error       : one-cycle pulse when a zero half-period is accepted
//   clock_signal    : divided clock (registered)
//   tick            : one-cycle pulse on each clock_signal rising edge
//   running         : high in RUN and SWITCH_PENDING
module clock_divider_controller #(
    parameter int unsigned REFERENCE_CLOCK     = 50_000_000,
    parameter int unsigned DEFAULT_FREQUENCY   = 25_000_000,
    parameter int unsigned NBITS_FOR_COUNTER   = 16,
    parameter int unsigned DEFAULT_HALF_PERIOD = REFERENCE_CLOCK / (2 * DEFAULT_FREQUENCY)
) (
    input  logic                         clk_FPGA,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         cfg_valid,
    input  logic [NBITS_FOR_COUNTER-1:0] cfg_half_period,
    output logic                         cfg_ready,
    output logic                         cfg_error,
    output logic                         clock_signal,
    output logic                         tick,
    output logic                         running
);

    localparam int unsigned W = NBITS_FOR_COUNTER;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_SWITCH = 2'd2,
        S_STOP   = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   counter_q, counter_d;
    logic [W-1:0]   active_h_q, active_h_d;
    logic [W-1:0]   pending_h_q, pending_h_d;
    logic           clk_q, clk_d;
    logic           tick_q, tick_d;
    logic           err_q, err_d;

    // Handshake and terminal-count decode
    logic           accept, accept_nz, accept_zero;
    logic           tc, rise, fall;
    logic [W-1:0]   cnt_adv;
    logic           clk_adv;

    assign accept      = cfg_valid && cfg_ready;
    assign accept_zero = accept && (cfg_half_period == '0);
    assign accept_nz   = accept && (cfg_half_period != '0);

    assign tc      = (counter_q == (active_h_q - W'(1)));
    assign rise    = tc && !clk_q;
    assign fall    = tc &&  clk_q;
    assign cnt_adv = tc ? '0 : (counter_q + W'(1));
    assign clk_adv = clk_q ^ tc;

    // State and datapath registers
    always_ff @(posedge clk_FPGA) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            counter_q   <= '0;
            active_h_q  <= W'(DEFAULT_HALF_PERIOD);
            pending_h_q <= '0;
            clk_q       <= 1'b0;
            tick_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            counter_q   <= counter_d;
            active_h_q  <= active_h_d;
            pending_h_q <= pending_h_d;
            clk_q       <= clk_d;
            tick_q      <= tick_d;
            err_q       <= err_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        counter_d   = counter_q;
        active_h_d  = active_h_q;
        pending_h_d = pending_h_q;
        clk_d       = clk_q;
        tick_d      = 1'b0;
        err_d       = accept_zero;

        case (state_q)
            S_IDLE: begin
                counter_d = '0;
                clk_d     = 1'b0;
                if (accept_nz) begin
                    active_h_d = cfg_half_period;
                end
                if (enable) begin
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                if (!enable && !clk_q) begin
                    // Low phase may be cut short; a config arriving now applies directly
                    state_d   = S_IDLE;
                    counter_d = '0;
                    clk_d     = 1'b0;
                    if (accept_nz) begin
                        active_h_d = cfg_half_period;
                    end
                end else begin
                    counter_d = cnt_adv;
                    clk_d     = clk_adv;
                    tick_d    = rise;
                    if (accept_nz) begin
                        // SWITCH_PENDING also handles a concurrent stop request
                        pending_h_d = cfg_half_period;
                        state_d     = S_SWITCH;
                    end else if (!enable) begin
                        state_d = fall ? S_IDLE : S_STOP;
                    end
                end
            end

            S_SWITCH: begin
                if (!enable && !clk_q) begin
                    state_d    = S_IDLE;
                    counter_d  = '0;
                    clk_d      = 1'b0;
                    active_h_d = pending_h_q;
                end else begin
                    counter_d = cnt_adv;
                    clk_d     = clk_adv;
                    tick_d    = rise;
                    // New rate starts with the low phase after this falling edge
                    if (fall) begin
                        active_h_d = pending_h_q;
                        state_d    = enable ? S_RUN : S_IDLE;
                    end
                end
            end

            S_STOP: begin
                // Entered only while high, so the next terminal count is the fall
                counter_d = cnt_adv;
                clk_d     = clk_adv;
                if (fall) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d   = S_IDLE;
                counter_d = '0;
                clk_d     = 1'b0;
            end
        endcase
    end

    // Outputs
    always_comb begin
        cfg_ready    = (state_q == S_IDLE) || (state_q == S_RUN);
        running      = (state_q == S_RUN)  || (state_q == S_SWITCH);
        clock_signal = clk_q;
        tick         = tick_q;
        cfg_error    = err_q;
    end

endmodule

// File: tb/tb_clock_divider_controller.sv
// Directed bench for clock_divider_controller: per-cycle output traces are
// compared against hand-derived bit patterns (bit i = value after edge i of
// the trace window).
module tb_clock_divider_controller;

    logic        clk_FPGA;
    logic        reset;
    logic        enable;
    logic        cfg_valid;
    logic [15:0] cfg_half_period;
    logic        cfg_ready;
    logic        cfg_error;
    logic        clock_signal;
    logic        tick;
    logic        running;

    int checks = 0;
    int errors = 0;

    logic [31:0] c_v, t_v, r_v, run_v, e_v;

    clock_divider_controller dut (
        .clk_FPGA        (clk_FPGA),
        .reset           (reset),
        .enable          (enable),
        .cfg_valid       (cfg_valid),
        .cfg_half_period (cfg_half_period),
        .cfg_ready       (cfg_ready),
        .cfg_error       (cfg_error),
        .clock_signal    (clock_signal),
        .tick            (tick),
        .running         (running)
    );

    initial clk_FPGA = 1'b0;
    always #5 clk_FPGA = ~clk_FPGA;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs n edges; enable held high before edge en_off_at, one cfg offered at edge cfg_at.
    task automatic capture(input int n, input int cfg_at, input logic [15:0] cfg_h,
                           input int en_off_at,
                           output logic [31:0] c, output logic [31:0] t,
                           output logic [31:0] r, output logic [31:0] run,
                           output logic [31:0] e);
        c = '0; t = '0; r = '0; run = '0; e = '0;
        for (int i = 0; i < n; i++) begin
            enable          = (i < en_off_at);
            cfg_valid       = (i == cfg_at);
            cfg_half_period = cfg_h;
            @(negedge clk_FPGA);
            c[i]   = clock_signal;
            t[i]   = tick;
            r[i]   = cfg_ready;
            run[i] = running;
            e[i]   = cfg_error;
        end
        cfg_valid = 1'b0;
    endtask

    // Stop, wait for IDLE (bounded), then load a half-period while idle.
    task automatic restart(input logic [15:0] h);
        logic found;
        found  = 1'b0;
        enable = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk_FPGA);
            if (!running && !clock_signal && cfg_ready) found = 1'b1;
        end
        chk("idle_reached", 32'(found), 32'd1);
        cfg_valid       = 1'b1;
        cfg_half_period = h;
        chk("idle_cfg_ready", 32'(cfg_ready), 32'd1);
        @(negedge clk_FPGA);
        cfg_valid = 1'b0;
        chk("idle_cfg_no_error", 32'(cfg_error), 32'd0);
        chk("idle_cfg_stays_idle", 32'(running), 32'd0);
    endtask

    initial begin
        reset           = 1'b0;
        enable          = 1'b0;
        cfg_valid       = 1'b0;
        cfg_half_period = '0;

        // Reset state
        repeat (2) @(negedge clk_FPGA);
        chk("rst_clock_signal", 32'(clock_signal), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_cfg_error", 32'(cfg_error), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);

        // Default rate: H=1, first rise one edge after RUN entry
        reset = 1'b1;
        capture(8, -1, 16'd0, 99, c_v, t_v, r_v, run_v, e_v);
        chk("def_clock", c_v, 32'h0000_00AA);
        chk("def_tick", t_v, 32'h0000_00AA);
        chk("def_running", run_v, 32'h0000_00FF);

        // Configure H=5 in IDLE
        restart(16'd5);
        capture(16, -1, 16'd0, 99, c_v, t_v, r_v, run_v, e_v);
        chk("h5_clock", c_v, 32'h0000_83E0);
        chk("h5_tick", t_v, 32'h0000_8020);
        chk("h5_running", run_v, 32'h0000_FFFF);

        // Mid-run change H=3 -> H=2 offered during the high phase
        restart(16'd3);
        capture(16, 4, 16'd2, 99, c_v, t_v, r_v, run_v, e_v);
        chk("sw_clock", c_v, 32'h0000_3338);
        chk("sw_tick", t_v, 32'h0000_1108);
        chk("sw_ready", r_v, 32'h0000_FFCF);
        chk("sw_running", run_v, 32'h0000_FFFF);
        chk("sw_error", e_v, 32'h0000_0000);

        // Stop one cycle into the high phase, H=4: high phase completes
        restart(16'd4);
        capture(16, -1, 16'd0, 5, c_v, t_v, r_v, run_v, e_v);
        chk("stop_hi_clock", c_v, 32'h0000_00F0);
        chk("stop_hi_tick", t_v, 32'h0000_0010);
        chk("stop_hi_running", run_v, 32'h0000_001F);
        chk("stop_hi_ready", r_v, 32'h0000_FF1F);

        // Stop during the low phase: immediate IDLE
        restart(16'd4);
        capture(16, -1, 16'd0, 9, c_v, t_v, r_v, run_v, e_v);
        chk("stop_lo_clock", c_v, 32'h0000_00F0);
        chk("stop_lo_tick", t_v, 32'h0000_0010);
        chk("stop_lo_running", run_v, 32'h0000_01FF);
        chk("stop_lo_ready", r_v, 32'h0000_FFFF);

        // Zero half-period rejected in RUN with H=3
        restart(16'd3);
        capture(16, 4, 16'd0, 99, c_v, t_v, r_v, run_v, e_v);
        chk("zero_clock", c_v, 32'h0000_8E38);
        chk("zero_tick", t_v, 32'h0000_8208);
        chk("zero_error", e_v, 32'h0000_0010);
        chk("zero_ready", r_v, 32'h0000_FFFF);
        chk("zero_running", run_v, 32'h0000_FFFF);

        // Reset while SWITCH_PENDING with pending H=7
        restart(16'd3);
        capture(5, 4, 16'd7, 99, c_v, t_v, r_v, run_v, e_v);
        chk("pend_clock", c_v, 32'h0000_0018);
        chk("pend_ready", r_v, 32'h0000_000F);
        chk("pend_running", run_v, 32'h0000_001F);
        reset = 1'b0;
        @(negedge clk_FPGA);
        chk("midrst_clock", 32'(clock_signal), 32'd0);
        chk("midrst_running", 32'(running), 32'd0);
        chk("midrst_ready", 32'(cfg_ready), 32'd1);
        chk("midrst_tick", 32'(tick), 32'd0);
        reset = 1'b1;
        capture(8, -1, 16'd0, 99, c_v, t_v, r_v, run_v, e_v);
        chk("postrst_clock", c_v, 32'h0000_00AA);
        chk("postrst_tick", t_v, 32'h0000_00AA);
        chk("postrst_running", run_v, 32'h0000_00FF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
